// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the ram_dma byte-RAM DMA engine.
package ram_dma_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF  = 16;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/ram_dma_if.sv
// Command, byte-stream and RAM bus bundle for ram_dma; master is the DMA side.
interface ram_dma_if
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              m_valid;
  logic              m_ready;
  logic [7:0]        m_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  s_valid, s_data,
    output s_ready,
    output m_valid, m_data,
    input  m_ready,
    output ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output s_valid, s_data,
    input  s_ready,
    input  m_valid, m_data,
    output m_ready,
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/ram_dma_skid.sv
// Two-entry read-data buffer for ram_dma; tracks the one RAM read in flight so
// that issued-plus-buffered bytes never exceed SKID_DEPTH.
module ram_dma_skid
  import ram_dma_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_i,
  input  logic [7:0] din_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       room_o
);

  logic       pend_q;
  logic [1:0] count_q, count_d;
  logic [7:0] head_q, head_d;
  logic [7:0] tail_q, tail_d;
  logic       pop;
  logic [2:0] occ;

  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign pop     = valid_o && ready_i;
  // A byte leaving this cycle frees its slot for an issue in the same cycle.
  assign occ     = {2'b00, pend_q} + {1'b0, count_q} - {2'b00, pop};
  assign room_o  = (occ < 3'(SKID_DEPTH));

  // Next state of the head/tail shift buffer.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({pend_q, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = din_i;
        end else begin
          tail_d = din_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Buffer registers; pend_q marks that ram_dout carries an issued byte this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= 1'b0;
      count_q <= 2'd0;
      head_q  <= 8'h00;
      tail_q  <= 8'h00;
    end else begin
      pend_q  <= issue_i;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/ram_dma.sv
// Single-command DMA between byte streams and a 1-cycle-latency byte RAM.
// Optional RAM_DMA_CHECKSUM_EN adds a mod-256 csum output over the transferred bytes.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  ram_dma_if.master  bus,
  output logic       busy,
  output logic       done
`ifdef RAM_DMA_CHECKSUM_EN
  ,
  output logic [7:0] csum
`endif
);

  state_e            state_q;
  logic              cmd_ready_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] cur_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  iss_rem_q;

  logic       cmd_fire;
  logic       s_fire;
  logic       m_fire;
  logic       issue;
  logic       room;
  logic       m_valid;
  logic [7:0] m_data;

  assign cmd_fire     = bus.cmd_valid && cmd_ready_q;
  assign bus.s_ready  = (state_q == WRITE);
  assign s_fire       = bus.s_valid && (state_q == WRITE);
  assign issue        = (state_q == READ) && (iss_rem_q != {LEN_W{1'b0}}) && room;
  assign m_fire       = m_valid && bus.m_ready;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.m_valid   = m_valid;
  assign bus.m_data    = m_data;
  // The write strobe rides the stream handshake so the byte lands on that same edge.
  assign bus.ram_we    = s_fire;
  assign bus.ram_addr  = (s_fire || issue) ? cur_q : {ADDR_W{1'b0}};
  assign bus.ram_din   = s_fire ? bus.s_data : 8'h00;
  assign busy          = busy_q;
  assign done          = done_q;

  ram_dma_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .issue_i (issue),
    .din_i   (bus.ram_dout),
    .ready_i (bus.m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .room_o  (room)
  );

  // Command FSM with registered cmd_ready/busy/done and the address/count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cur_q       <= {ADDR_W{1'b0}};
      rem_q       <= {LEN_W{1'b0}};
      iss_rem_q   <= {LEN_W{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            cur_q       <= bus.cmd_addr;
            rem_q       <= bus.cmd_len;
            iss_rem_q   <= bus.cmd_len;
            if (bus.cmd_len == {LEN_W{1'b0}}) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= bus.cmd_write ? WRITE : READ;
              busy_q  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (s_fire) begin
            cur_q <= cur_q + ADDR_W'(1'b1);
            rem_q <= rem_q - LEN_W'(1'b1);
            if (rem_q == LEN_W'(1'b1)) begin
              state_q <= FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            cur_q     <= cur_q + ADDR_W'(1'b1);
            iss_rem_q <= iss_rem_q - LEN_W'(1'b1);
          end
          if (m_fire) begin
            rem_q <= rem_q - LEN_W'(1'b1);
            if (rem_q == LEN_W'(1'b1)) begin
              state_q <= FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_DMA_CHECKSUM_EN
  logic [7:0] csum_q;

  assign csum = csum_q;

  // Running byte sum, cleared on accept and held after the command ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else if (cmd_fire) begin
      csum_q <= 8'h00;
    end else if (s_fire) begin
      csum_q <= csum_q + bus.s_data;
    end else if (m_fire) begin
      csum_q <= csum_q + m_data;
    end else begin
      csum_q <= csum_q;
    end
  end
`endif

endmodule

// File: tb/tb_ram_dma.sv
// Directed testbench for ram_dma with a behavioural 64 KiB byte RAM.
module tb_ram_dma;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic done;
`ifdef RAM_DMA_CHECKSUM_EN
  logic [7:0] csum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:65535];

  ram_dma_if #(.ADDR_W(16), .LEN_W(16)) bus ();

  ram_dma #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
`ifdef RAM_DMA_CHECKSUM_EN
    ,
    .csum  (csum)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: write on edge, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 5);
  endfunction

  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [15:0] len,
                          output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 16'h0000;
    bus.cmd_len   = 16'h0000;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    bus.m_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b expected 0", bus.cmd_ready);
    end
    n_checks++;
    if ({bus.s_ready, bus.m_valid, bus.ram_we, busy, done} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_flags: got s_ready,m_valid,ram_we,busy,done=%b expected 00000",
               {bus.s_ready, bus.m_valid, bus.ram_we, busy, done});
    end
    n_checks++;
    if ({bus.ram_addr, bus.ram_din, bus.m_data} !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h din=%h m_data=%h expected zeros",
               bus.ram_addr, bus.ram_din, bus.m_data);
    end
`ifdef RAM_DMA_CHECKSUM_EN
    n_checks++;
    if (csum !== 8'h00) begin
      n_fail++; $display("FAIL reset_csum: got %h expected 00", csum);
    end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_cmd_ready: got %b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write(input logic [15:0] addr, input int len,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
    bit ok;
    logic [7:0]  d [4];
    logic [15:0] a;
    d = '{d0, d1, d2, d3};
    bus.s_valid = 1'b0;
    send_cmd(1'b1, addr, 16'(len), ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL write_accept: got %b expected 1", ok);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d[0];
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      a = addr + 16'(i);
      n_checks++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_din, busy} !== {1'b1, a, d[i], 1'b1}) begin
        n_fail++;
        $display("FAIL write_beat%0d: got we=%b addr=%h din=%h busy=%b expected 1 %h %h 1",
                 i, bus.ram_we, bus.ram_addr, bus.ram_din, busy, a, d[i]);
      end
      @(posedge clk); #1;
      if (i < len - 1) bus.s_data = d[i+1];
      else bus.s_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy, bus.cmd_ready, bus.ram_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL write_done: got done,busy,cmd_ready,we=%b expected 1000",
               {done, busy, bus.cmd_ready, bus.ram_we});
    end
    @(negedge clk);
    n_checks++;
    if ({done, bus.cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL write_idle: got done,cmd_ready=%b expected 01", {done, bus.cmd_ready});
    end
    for (int i = 0; i < len; i++) begin
      a = addr + 16'(i);
      n_checks++;
      if (mem[a] !== d[i]) begin
        n_fail++; $display("FAIL write_mem[%h]: got %h expected %h", a, mem[a], d[i]);
      end
    end
  endtask

  task automatic test_read4();
    bit ok;
    int first_n, last_n, done_n, got;
    logic [7:0] e [4];
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    first_n = -1; last_n = -1; done_n = -1; got = 0;
    bus.m_ready = 1'b1;
    send_cmd(1'b0, 16'h0100, 16'd4, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL read4_accept: got %b expected 1", ok);
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        if (first_n < 0) first_n = n;
        n_checks++;
        if (got >= 4 || bus.m_data !== e[got]) begin
          n_fail++; $display("FAIL read4_byte%0d: got %h", got, bus.m_data);
        end
        got++;
        last_n = n;
      end
      if (done) done_n = n;
    end
    bus.m_ready = 1'b0;
    n_checks++;
    if (first_n !== 2) begin
      n_fail++; $display("FAIL read4_latency: got %0d expected 2", first_n);
    end
    n_checks++;
    if ({got, last_n, done_n} !== {32'd4, 32'd5, 32'd6}) begin
      n_fail++; $display("FAIL read4_timing: got count=%0d last=%0d done=%0d expected 4 5 6",
                         got, last_n, done_n);
    end
  endtask

  task automatic test_wrap();
    test_write(16'hFFFE, 3, 8'hA1, 8'hB2, 8'hC3, 8'h00);
    n_checks++;
    if ({mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]} !== 24'hA1B2C3) begin
      n_fail++; $display("FAIL wrap_mem: got %h%h%h expected a1b2c3",
                         mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]);
    end
  endtask

  task automatic test_len0();
    bit ok;
    int done_cnt, done_n, we_cnt, mv_cnt, busy_cnt;
    logic rdy0, rdy1;
    done_cnt = 0; done_n = -1; we_cnt = 0; mv_cnt = 0; busy_cnt = 0;
    rdy0 = 1'b1; rdy1 = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    bus.m_ready = 1'b1;
    send_cmd(1'b1, 16'h0400, 16'd0, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL len0_accept: got %b expected 1", ok);
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done) begin done_cnt++; if (done_n < 0) done_n = n; end
      if (bus.ram_we) we_cnt++;
      if (bus.m_valid) mv_cnt++;
      if (busy) busy_cnt++;
      if (n == 0) rdy0 = bus.cmd_ready;
      if (n == 1) rdy1 = bus.cmd_ready;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    n_checks++;
    if ({done_cnt, done_n} !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL len0_done: got pulses=%0d at=%0d expected 1 0", done_cnt, done_n);
    end
    n_checks++;
    if ({we_cnt, mv_cnt, busy_cnt} !== {32'd0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL len0_quiet: got we=%0d m_valid=%0d busy=%0d expected 0 0 0",
                         we_cnt, mv_cnt, busy_cnt);
    end
    n_checks++;
    if ({rdy0, rdy1} !== 2'b01) begin
      n_fail++; $display("FAIL len0_cmd_ready: got %b expected 01", {rdy0, rdy1});
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    send_cmd(1'b1, 16'h0500, 16'd1, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got %b expected 1", ok);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h66;
    @(negedge clk);
    n_checks++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, 16'h0500, 8'h66}) begin
      n_fail++; $display("FAIL b2b_beat1: got we=%b addr=%h din=%h expected 1 0500 66",
                         bus.ram_we, bus.ram_addr, bus.ram_din);
    end
    @(posedge clk); #1;
    bus.s_valid   = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 16'h0600;
    bus.cmd_len   = 16'd1;
    @(negedge clk);
    n_checks++;
    if ({done, bus.cmd_ready} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_done_no_accept: got done,cmd_ready=%b expected 10",
                         {done, bus.cmd_ready});
    end
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept_after_done: got %b expected 1", bus.cmd_ready);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.s_valid   = 1'b1;
    bus.s_data    = 8'h77;
    @(negedge clk);
    n_checks++;
    if ({busy, bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, 1'b1, 16'h0600, 8'h77}) begin
      n_fail++; $display("FAIL b2b_beat2: got busy=%b we=%b addr=%h din=%h expected 1 1 0600 77",
                         busy, bus.ram_we, bus.ram_addr, bus.ram_din);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({done, mem[16'h0500], mem[16'h0600]} !== {1'b1, 8'h66, 8'h77}) begin
      n_fail++; $display("FAIL b2b_end: got done=%b mem=%h,%h expected 1 66,77",
                         done, mem[16'h0500], mem[16'h0600]);
    end
  endtask

  task automatic test_random_stream();
    bit ok;
    int idx, rcv, iss, ahead, max_ahead;
    bit wdone, rdone;
    idx = 0; wdone = 1'b0;
    send_cmd(1'b1, 16'h0200, 16'd200, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL rnd_wr_accept: got %b expected 1", ok);
    end
    bus.s_valid = 1'($urandom_range(0, 1));
    bus.s_data  = pat(0);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) idx++;
      if (done) begin wdone = 1'b1; break; end
      @(posedge clk); #1;
      if (idx < 200) begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.s_data  = pat(idx);
      end else begin
        bus.s_valid = 1'b0;
      end
    end
    bus.s_valid = 1'b0;
    n_checks++;
    if ({wdone, idx} !== {1'b1, 32'd200}) begin
      n_fail++; $display("FAIL rnd_wr_count: got done=%b bytes=%0d expected 1 200", wdone, idx);
    end

    rcv = 0; iss = 0; max_ahead = 0; rdone = 1'b0;
    bus.m_ready = 1'($urandom_range(0, 1));
    send_cmd(1'b0, 16'h0200, 16'd200, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL rnd_rd_accept: got %b expected 1", ok);
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.ram_addr != 16'h0000) iss++;
      if (bus.m_valid && bus.m_ready) begin
        n_checks++;
        if (bus.m_data !== pat(rcv)) begin
          n_fail++; $display("FAIL rnd_rd_byte%0d: got %h expected %h", rcv, bus.m_data, pat(rcv));
        end
        rcv++;
      end
      ahead = iss - rcv;
      if (ahead > max_ahead) max_ahead = ahead;
      if (done) begin rdone = 1'b1; break; end
      @(posedge clk); #1;
      bus.m_ready = 1'($urandom_range(0, 1));
    end
    bus.m_ready = 1'b0;
    n_checks++;
    if ({rdone, rcv, iss} !== {1'b1, 32'd200, 32'd200}) begin
      n_fail++; $display("FAIL rnd_rd_count: got done=%b recv=%0d issued=%0d expected 1 200 200",
                         rdone, rcv, iss);
    end
    n_checks++;
    if (max_ahead > 2) begin
      n_fail++; $display("FAIL rnd_rd_ahead: got %0d expected <= 2", max_ahead);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int got;
    got = 0;
    bus.m_ready = 1'b0;
    send_cmd(1'b0, 16'h0200, 16'd16, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL rst_rd_accept: got %b expected 1", ok);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if ({bus.m_valid, busy} !== 2'b11) begin
      n_fail++; $display("FAIL rst_rd_stalled: got m_valid,busy=%b expected 11", {bus.m_valid, busy});
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        n_checks++;
        if (bus.m_data !== pat(got)) begin
          n_fail++; $display("FAIL rst_rd_byte%0d: got %h expected %h", got, bus.m_data, pat(got));
        end
        got++;
      end
    end
    n_checks++;
    if (got !== 3) begin
      n_fail++; $display("FAIL rst_rd_count: got %0d expected 3", got);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.m_valid, busy, bus.ram_we, bus.cmd_ready, done, bus.m_data} !== 13'h0000) begin
      n_fail++; $display("FAIL rst_rd_abort: got m_valid,busy,we,cmd_ready,done=%b m_data=%h expected zeros",
                         {bus.m_valid, busy, bus.ram_we, bus.cmd_ready, done}, bus.m_data);
    end
    @(posedge clk); #1;
    reset       = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
  endtask

`ifdef RAM_DMA_CHECKSUM_EN
  task automatic test_checksum();
    test_write(16'h0700, 2, 8'hFF, 8'h02, 8'h00, 8'h00);
    n_checks++;
    if (csum !== 8'h01) begin
      n_fail++; $display("FAIL csum_write: got %h expected 01", csum);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write(16'h0100, 4, 8'h11, 8'h22, 8'h33, 8'h44);
    test_read4();
    test_wrap();
    test_len0();
    test_back_to_back();
    test_random_stream();
    test_reset_mid_read();
    test_read4();
`ifdef RAM_DMA_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
